// File: rtl/rd_ptr_empty_ctrl.sv
// Read-side pointer and empty/status flag generator for an async FIFO.
// Lives entirely in the read clock domain. It takes the Gray write pointer,
// already synchronised to the read clock, and produces the RAM read address,
// the Gray read pointer for the write side, and registered fill status.
module rd_ptr_empty_ctrl #(
    parameter int WIDTH           = 8,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic             i_RD_clk,
    input  logic             i_RD_rst,
    input  logic             i_RD_en,
    input  logic [WIDTH:0]   i_Sync_WR_Ptr,
    output logic [WIDTH-1:0] o_RD_Addr,
    output logic [WIDTH:0]   o_RD_Ptr,
    output logic             o_Empty,
    output logic             o_Almost_Empty,
    output logic [WIDTH:0]   o_RD_Count,
    output logic             o_Underflow
);

    localparam logic [WIDTH:0] AE_TH = (WIDTH+1)'(ALMOST_EMPTY_TH);

    logic [WIDTH:0] r_bin;
    logic [WIDTH:0] r_gray;
    logic           r_empty;
    logic           r_almost_empty;
    logic [WIDTH:0] r_count;
    logic           r_underflow;

    logic           w_rd_acc;
    logic [WIDTH:0] w_bin_next;
    logic [WIDTH:0] w_gray_next;
    logic [WIDTH:0] w_wr_bin;
    logic [WIDTH:0] w_fill;

    // Next pointer values, write-pointer decode and fill level
    always_comb begin
        w_rd_acc    = i_RD_en & ~r_empty;
        w_bin_next  = r_bin + {{WIDTH{1'b0}}, w_rd_acc};
        w_gray_next = w_bin_next ^ (w_bin_next >> 1);
        w_wr_bin    = '0;
        // Each binary bit is the XOR of all Gray bits at and above it.
        for (int i = 0; i <= WIDTH; i++) begin
            w_wr_bin[i] = ^(i_Sync_WR_Ptr >> i);
        end
        // Both pointers are one bit wider than the address, so the modular
        // difference spans 0..2**WIDTH without ambiguity.
        w_fill = w_wr_bin - w_bin_next;
    end

    // Pointer and status registers; flags are evaluated against the
    // post-read pointer so the last read and the empty flag land together.
    always_ff @(posedge i_RD_clk) begin
        if (i_RD_rst) begin
            r_bin          <= '0;
            r_gray         <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_count        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_bin          <= w_bin_next;
            r_gray         <= w_gray_next;
            r_empty        <= (w_gray_next == i_Sync_WR_Ptr);
            r_almost_empty <= (w_fill <= AE_TH);
            r_count        <= w_fill;
            r_underflow    <= i_RD_en & r_empty;
        end
    end

    assign o_RD_Addr      = r_bin[WIDTH-1:0];
    assign o_RD_Ptr       = r_gray;
    assign o_Empty        = r_empty;
    assign o_Almost_Empty = r_almost_empty;
    assign o_RD_Count     = r_count;
    assign o_Underflow    = r_underflow;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Scoreboard bench for rd_ptr_empty_ctrl (WIDTH=3, ALMOST_EMPTY_TH=2).
// The model tracks total words written/read as plain integers; expected
// outputs after each edge are queued and checked by an independent monitor.
module tb_rd_ptr_empty_ctrl;

    localparam int W  = 3;
    localparam int TH = 2;

    logic         clk = 1'b0;
    logic         i_RD_rst;
    logic         i_RD_en;
    logic [W:0]   i_Sync_WR_Ptr;
    logic [W-1:0] o_RD_Addr;
    logic [W:0]   o_RD_Ptr;
    logic         o_Empty;
    logic         o_Almost_Empty;
    logic [W:0]   o_RD_Count;
    logic         o_Underflow;

    rd_ptr_empty_ctrl #(.WIDTH(W), .ALMOST_EMPTY_TH(TH)) dut (
        .i_RD_clk      (clk),
        .i_RD_rst      (i_RD_rst),
        .i_RD_en       (i_RD_en),
        .i_Sync_WR_Ptr (i_Sync_WR_Ptr),
        .o_RD_Addr     (o_RD_Addr),
        .o_RD_Ptr      (o_RD_Ptr),
        .o_Empty       (o_Empty),
        .o_Almost_Empty(o_Almost_Empty),
        .o_RD_Count    (o_RD_Count),
        .o_Underflow   (o_Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ptr;
        int empty;
        int ae;
        int count;
        int ufl;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 0;

    // Model state: total words read, current synchronised write total, last flags
    int m_reads = 0;
    int m_w     = 0;
    int m_empty = 1;

    function automatic int gray(input int v);
        int m;
        m = v % (1 << (W + 1));
        return m ^ (m >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; expected post-edge outputs go to the scoreboard
    task automatic step(input bit rst, input bit en, input int w);
        exp_t e;
        int   fill;
        @(negedge clk);
        i_RD_rst      = rst;
        i_RD_en       = en;
        i_Sync_WR_Ptr = (W+1)'(gray(w));
        m_w           = w;
        if (rst) begin
            m_reads = 0;
            e.empty = 1; e.ae = 1; e.count = 0; e.ufl = 0;
        end else begin
            e.ufl = (en && m_empty) ? 1 : 0;
            if (en && !m_empty) m_reads++;
            fill    = w - m_reads;
            e.count = fill;
            e.empty = (fill == 0) ? 1 : 0;
            e.ae    = (fill <= TH) ? 1 : 0;
        end
        e.addr  = m_reads % (1 << W);
        e.ptr   = gray(m_reads);
        m_empty = e.empty;
        sb_q.push_back(e);
    endtask

    // Monitor: the block presents a full status word every cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("addr",   int'(o_RD_Addr),      e.addr);
                chk("rd_ptr", int'(o_RD_Ptr),       e.ptr);
                chk("empty",  int'(o_Empty),        e.empty);
                chk("almost", int'(o_Almost_Empty), e.ae);
                chk("count",  int'(o_RD_Count),     e.count);
                chk("ufl",    int'(o_Underflow),    e.ufl);
            end
        end
    end

    initial begin
        int w;
        i_RD_rst = 1'b1; i_RD_en = 1'b0; i_Sync_WR_Ptr = '0;

        // Reset with write pointer at zero
        step(1, 0, 0);
        step(1, 1, 0);

        // Writes appear one at a time, no reads
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 2);
        step(0, 0, 3);
        step(0, 0, 3);

        // Drain three words with read held for four cycles
        for (int i = 0; i < 4; i++) step(0, 1, 3);
        step(0, 0, 3);

        // Wrap: writes stay ahead of reads through 20 reads
        w = 5;
        step(0, 0, 4);
        step(0, 0, 5);
        for (int i = 0; i < 20; i++) begin
            w++;
            step(0, 1, w);
        end
        for (int i = 0; i < 4; i++) step(0, 1, w);

        // Full view: eight words written, nothing read
        step(1, 0, 0);
        for (int i = 1; i <= 8; i++) step(0, 0, i);
        step(0, 0, 8);

        // Reset in mid-stream with read asserted
        step(1, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 0, i);
        step(0, 1, 5);
        step(1, 1, 5);
        step(0, 0, 0);

        // Random traffic: write total never decreases, moves at most one step
        // per cycle (Gray-legal) and never exceeds the read total by more than depth
        w = 0;
        step(1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 3) != 0 && (w + 1 - m_reads) <= (1 << W)) w++;
            step(0, ($urandom % 2) == 1, w);
        end
        for (int i = 0; i < 12; i++) step(0, 1, w);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
